// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for a 5-stage pipeline sharing one clock
// with independent instruction and data memories that respond with variable
// latency. The pipeline advances only when both memories have answered for
// the current cycle; a response that arrives early is remembered in the FSM
// so the other side can finish without re-requesting.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   rst          asynchronous active-high reset
//   imem_resp    instruction memory response valid this cycle
//   dmem_access  EX/MEM instruction is a load or store
//   dmem_resp    data memory response valid this cycle
//   load_use     ID instruction depends on a load in EX
//   redirect     taken branch/jump resolved in EX
//   imem_read    instruction fetch request
//   dmem_enable  MEM-stage read/write strobe gate
//   load_*       load enables for PC and the four stage registers
//   flush_*      replace loaded stage-register contents with a bubble
//   stall_count  saturating count of cycles the pipeline did not advance
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_resp,
  input  logic        dmem_access,
  input  logic        dmem_resp,
  input  logic        load_use,
  input  logic        redirect,
  output logic        imem_read,
  output logic        dmem_enable,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] stall_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    BOTH_PEND = 2'd0,
    I_DONE    = 2'd1,
    D_DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   stall_q;
  logic               i_ok;
  logic               d_ok;
  logic               advance;

  // A side is satisfied by a response now or one captured earlier.
  assign i_ok    = imem_resp || (state == I_DONE);
  assign d_ok    = !dmem_access || dmem_resp || (state == D_DONE);
  assign advance = i_ok && d_ok;

  assign stall_count = stall_q;

  // Response-capture FSM; only BOTH_PEND can capture, so a repeated
  // response from the already-captured side is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOTH_PEND;
    end else if (advance) begin
      state <= BOTH_PEND;
    end else if (state == BOTH_PEND) begin
      if (imem_resp) begin
        state <= I_DONE;
      end else if (dmem_resp) begin
        state <= D_DONE;
      end
    end
  end

  // Stall cycle counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!advance && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Request, load and flush decode; everything is quiet while in reset.
  always_comb begin
    imem_read   = 1'b0;
    dmem_enable = 1'b0;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      imem_read   = (state != I_DONE);
      dmem_enable = dmem_access && (state != D_DONE);
      if (advance) begin
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        if (redirect) begin
          // Wrong-path instructions in IF/ID and ID/EX are squashed.
          load_pc     = 1'b1;
          load_if_id  = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, insert a bubble behind the load.
          flush_id_ex = 1'b1;
        end else begin
          load_pc    = 1'b1;
          load_if_id = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_resp = 1'b0;
  logic        dmem_access = 1'b0;
  logic        dmem_resp = 1'b0;
  logic        load_use = 1'b0;
  logic        redirect = 1'b0;
  logic        imem_read, dmem_enable;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex;
  logic [31:0] stall_count;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_access(dmem_access),
    .dmem_resp(dmem_resp), .load_use(load_use), .redirect(redirect),
    .imem_read(imem_read), .dmem_enable(dmem_enable), .load_pc(load_pc),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 0;

  // Reference model: which memory answers are already in hand, and the count.
  bit          have_i = 0;
  bit          have_d = 0;
  logic [31:0] m_stall = '0;

  // One cycle: drive at negedge, queue the expected response, advance model.
  task automatic step(input bit r, input bit ia, input bit da, input bit dr,
                      input bit lu, input bit rd, input bit pulse, input bit pl);
    exp_t e;
    bit   ok_i, ok_d, adv;
    logic [6:0] lf;
    @(negedge clk);
    if (pl) begin
      dut.stall_q = 32'hFFFF_FFFE;
      m_stall     = 32'hFFFF_FFFE;
    end
    rst = r; imem_resp = ia; dmem_access = da; dmem_resp = dr;
    load_use = lu; redirect = rd;
    if (r) begin
      have_i = 0; have_d = 0; m_stall = '0;
    end
    ok_i = have_i || ia;
    ok_d = !da || have_d || dr;
    adv  = ok_i && ok_d;
    if (!adv)      lf = 7'b0000000;
    else if (rd)   lf = 7'b1111111;
    else if (lu)   lf = 7'b0011101;
    else           lf = 7'b1111100;
    if (r) begin
      e.ctl = '0;
      e.cnt = '0;
    end else begin
      e.ctl = {!have_i, da && !have_d, lf};
      e.cnt = m_stall;
    end
    exp_q.push_back(e);
    if (pulse) begin
      #4 rst = 1'b0;
    end
    if (!r || pulse) begin
      if (!adv && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (adv) begin
        have_i = 0; have_d = 0;
      end else if (!have_i && !have_d) begin
        if (ia) have_i = 1;
        else if (dr) have_d = 1;
      end
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t  e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {imem_read, dmem_enable, load_pc, load_if_id, load_id_ex,
               load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
        end
        checks++;
        if (stall_count !== e.cnt) begin
          errors++;
          $display("FAIL stall_count t=%0t actual=%h required=%h", $time, stall_count, e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, then free-running fetch with no data accesses.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    // imem answers at cycle 1, dmem at cycle 4.
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // Simultaneous responses with load_use; then redirect overriding load_use.
    step(0, 1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0, 0);
    // Saturation from a preloaded count.
    step(0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    // Enter D_DONE, then a reset pulse between edges discards the capture.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, p;
      r = ($urandom_range(99) == 0);
      p = r && ($urandom_range(1) == 0);
      step(r, $urandom_range(99) < 45, $urandom_range(99) < 55,
           $urandom_range(99) < 35, $urandom_range(99) < 20,
           $urandom_range(99) < 15, p, 0);
    end
    step(0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port imem_resp, input, 1, instruction memory response valid this cycle.
REQ-004 SHALL have port dmem_access, input, 1, the instruction held in the EX/MEM stage register performs a load or store.
REQ-005 SHALL have port dmem_resp, input, 1, data memory response valid this cycle.
REQ-006 SHALL have port load_use, input, 1, ID stage instruction depends on a load currently in EX.
REQ-007 SHALL have port redirect, input, 1, taken branch or jump resolved in EX.
REQ-008 SHALL have port imem_read, output, 1, instruction fetch request.
REQ-009 SHALL have port dmem_enable, output, 1, gates the MEM-stage read/write strobe.
REQ-010 SHALL have ports load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, output, 1 each, the load enables of the PC and the four stage registers.
REQ-011 SHALL have ports flush_if_id, flush_id_ex, output, 1 each, replace the loaded stage-register contents with a bubble (no-op control word).
REQ-012 SHALL have port stall_count, output, 32, number of cycles the pipeline did not advance.

Function
REQ-013 SHALL hold a 3-state FSM: BOTH_PEND (no response captured), I_DONE (imem response captured, dmem pending), D_DONE (dmem response captured, imem pending).
REQ-014 SHALL compute i_ok = imem_resp or state==I_DONE; d_ok = !dmem_access or dmem_resp or state==D_DONE; advance = i_ok and d_ok.
REQ-015 SHALL transition: BOTH_PEND -> I_DONE on imem_resp and !advance; BOTH_PEND -> D_DONE on dmem_resp and !advance; any state -> BOTH_PEND on advance; otherwise hold.
REQ-016 SHALL drive imem_read = 1 when state != I_DONE, 0 in I_DONE.
REQ-017 SHALL drive dmem_enable = dmem_access and state != D_DONE.
REQ-018 SHALL, when advance=0, drive all five load enables and both flushes to 0 (full-pipeline freeze).
REQ-019 SHALL, when advance=1 and redirect=1, drive all loads 1 and flush_if_id=flush_id_ex=1, regardless of load_use.
REQ-020 SHALL, when advance=1, redirect=0, load_use=1, drive load_pc=load_if_id=0, load_id_ex=load_ex_mem=load_mem_wb=1, flush_id_ex=1, flush_if_id=0; the fetched instruction is discarded and refetched from the unchanged PC.
REQ-021 SHALL, when advance=1 with no redirect and no load_use, drive all loads 1 and both flushes 0.
REQ-022 SHALL treat simultaneous imem_resp and dmem_resp in BOTH_PEND as advance in that same cycle (zero extra latency).
REQ-023 SHALL ignore dmem_resp in D_DONE and imem_resp in I_DONE (no double capture).
REQ-024 SHALL increment stall_count by 1 on each clock edge with advance=0, saturating at 0xFFFFFFFF (no wrap).
REQ-025 SHALL produce all load/flush/request outputs combinationally from current state and inputs; one advance per cycle maximum.

Reset
REQ-026 SHALL, while rst=1, force state to BOTH_PEND and stall_count to 0 immediately, independent of clk.
REQ-027 SHALL, while rst=1, drive imem_read, dmem_enable, all loads and flushes to 0.
REQ-028 SHALL, on rst asserted mid-wait (I_DONE or D_DONE), discard the captured response; first cycle after release is BOTH_PEND.

Verification
REQ-029 SHALL cover: dmem_access=0, imem_resp=1 every cycle -> all loads 1 each cycle, stall_count stays 0.
REQ-030 SHALL cover: dmem_access=1, imem_resp at cycle 1, dmem_resp at cycle 4 -> state I_DONE cycles 2-4, imem_read=0 cycles 2-4, single advance at cycle 4, stall_count=3.
REQ-031 SHALL cover: imem_resp and dmem_resp same cycle with load_use=1 -> load_pc=0, load_if_id=0, flush_id_ex=1, others load 1.
REQ-032 SHALL cover: redirect=1 and load_use=1 on an advance cycle -> all loads 1, both flushes 1.
REQ-033 SHALL cover: stall_count preloaded to 0xFFFFFFFE, 3 stall cycles -> reads 0xFFFFFFFF, no wrap.
REQ-034 SHALL cover: rst pulsed between clock edges while in D_DONE -> state BOTH_PEND, stall_count 0, all outputs 0 before next edge.
